regfile: RTL and testbench



---
 rtl/regfile.sv | 69 ++++++
 tb/tb_regfile.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// regfile -- sixteen 16-bit general-purpose registers for the 16-bit CPU
// datapath. Two combinational read ports, one synchronous write port; the
// destination field rDst is both a read address and the write address.
//
// Ports:
//   clk        : system clock, state updates on the rising edge
//   rst_n      : asynchronous active-low reset, clears every register
//   write      : write enable, stores writeData into regs[rDst] at the edge
//   rSrc       : source read address            -> dSrc
//   rDst       : destination read/write address -> dDst
//   pc         : program counter from fetch, not used by this block
//   write_data : data to store
//   dSrc/dDst  : register contents at rSrc/rDst (no write bypass)

// One 16-bit storage cell; the register file instantiates an array of these.
module regCell (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [15:0] d,
    output logic [15:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (we) q <= d;
    end
endmodule

module regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        write,
    input  logic [3:0]  rSrc,
    input  logic [3:0]  rDst,
    input  logic [15:0] pc,
    input  logic [15:0] write_data,
    output logic [15:0] dSrc,
    output logic [15:0] dDst
);
    localparam int NUM_REGS = 16;
    localparam int REG_W    = 16;

    logic [NUM_REGS-1:0][REG_W-1:0] regQ;
    logic [NUM_REGS-1:0]            weVec;

    // pc is part of the decode-stage bundle but has no role here.
    logic unusedPc;
    assign unusedPc = ^pc;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : gReg
            assign weVec[gi] = write && (rDst == 4'(gi));
            regCell uCell (
                .clk (clk),
                .rst_n (rst_n),
                .we  (weVec[gi]),
                .d   (write_data),
                .q   (regQ[gi])
            );
        end
    endgenerate

    // Reads come straight from the stored state, so a pending write is not
    // visible until its edge commits it. Reset clears the cells
    // asynchronously, which already forces both ports to zero.
    assign dSrc = regQ[rSrc];
    assign dDst = regQ[rDst];
endmodule

// File: tb/tb_regfile.sv
`timescale 1ns/1ps
module tb_regfile;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        write;
    logic [3:0]  rSrc, rDst;
    logic [15:0] pc, write_data;
    logic [15:0] dSrc, dDst;

    int checks = 0;
    int errors = 0;

    logic [15:0] model [16];
    logic [15:0] expSrcQ [$];
    logic [15:0] expDstQ [$];
    logic [15:0] eS, eD;

    regfile dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .write      (write),
        .rSrc       (rSrc),
        .rDst       (rDst),
        .pc         (pc),
        .write_data (write_data),
        .dSrc       (dSrc),
        .dDst       (dDst)
    );

    always #5 clk = ~clk;

    // Stimulus only: one write over one rising edge, tracked in the model.
    task automatic doWrite(input logic [3:0] a, input logic [15:0] v);
        @(negedge clk);
        write = 1'b1; rDst = a; write_data = v;
        @(posedge clk);
        if (rst_n) model[a] = v;
        #1 write = 1'b0;
    endtask

    task automatic test_reset;
        // power-on state
        @(negedge clk);
        rSrc = 4'd0; rDst = 4'd9;
        expSrcQ.push_back(16'h0000); expDstQ.push_back(16'h0000);
        #1;
        eS = expSrcQ.pop_front(); eD = expDstQ.pop_front();
        checks++; if (dSrc !== eS) begin errors++; $display("FAIL por_dSrc got %h exp %h", dSrc, eS); end
        checks++; if (dDst !== eD) begin errors++; $display("FAIL por_dDst got %h exp %h", dDst, eD); end
        @(negedge clk) rst_n = 1'b1;
        // fill with arbitrary contents, then assert reset between edges
        for (int i = 0; i < 16; i++) doWrite(4'(i), 16'($urandom_range(1, 16'hFFFF)));
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rSrc = 4'(i); rDst = 4'(15 - i);
            expSrcQ.push_back(16'h0000); expDstQ.push_back(16'h0000);
            #0.2;
            eS = expSrcQ.pop_front(); eD = expDstQ.pop_front();
            checks++; if (dSrc !== eS) begin errors++; $display("FAIL async_rst_dSrc r%0d got %h exp %h", i, dSrc, eS); end
            checks++; if (dDst !== eD) begin errors++; $display("FAIL async_rst_dDst r%0d got %h exp %h", 15 - i, dDst, eD); end
        end
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;
        // a write during reset is ignored
        doWrite(4'd7, 16'hFFFF);
        rDst = 4'd7; rSrc = 4'd7;
        expDstQ.push_back(16'h0000);
        #1;
        eD = expDstQ.pop_front();
        checks++; if (dDst !== eD) begin errors++; $display("FAIL rst_write_ignored got %h exp %h", dDst, eD); end
        // release; the write on the first edge afterward is performed
        @(negedge clk);
        rst_n = 1'b1;
        doWrite(4'd2, 16'h1357);
        rDst = 4'd2;
        expDstQ.push_back(16'h1357);
        #1;
        eD = expDstQ.pop_front();
        checks++; if (dDst !== eD) begin errors++; $display("FAIL first_write_after_rst got %h exp %h", dDst, eD); end
    endtask

    task automatic test_write_all(input logic [15:0] val, input string tag);
        for (int i = 0; i < 16; i++) doWrite(4'(i), val);
        for (int i = 0; i < 16; i++) begin
            rDst = 4'(i); rSrc = ~4'(i);
            expSrcQ.push_back(val); expDstQ.push_back(val);
            #1;
            eS = expSrcQ.pop_front(); eD = expDstQ.pop_front();
            checks++; if (dSrc !== eS) begin errors++; $display("FAIL %s_dSrc r%0d got %h exp %h", tag, 15 - i, dSrc, eS); end
            checks++; if (dDst !== eD) begin errors++; $display("FAIL %s_dDst r%0d got %h exp %h", tag, i, dDst, eD); end
        end
    endtask

    task automatic test_write_disabled;
        doWrite(4'd3, 16'hA5A5);
        @(negedge clk);
        write = 1'b0; rDst = 4'd3; write_data = 16'h1234;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            expDstQ.push_back(16'hA5A5);
            #1;
            eD = expDstQ.pop_front();
            checks++; if (dDst !== eD) begin errors++; $display("FAIL write_disabled edge%0d got %h exp %h", k, dDst, eD); end
        end
    endtask

    task automatic test_independent;
        for (int i = 0; i < 16; i++) doWrite(4'(i), 16'(i * 16'h0101));
        for (int i = 0; i < 16; i++) begin
            rSrc = 4'(i); rDst = 4'(15 - i);
            expSrcQ.push_back(16'(i * 16'h0101));
            expDstQ.push_back(16'((15 - i) * 16'h0101));
            #1;
            eS = expSrcQ.pop_front(); eD = expDstQ.pop_front();
            checks++; if (dSrc !== eS) begin errors++; $display("FAIL indep_dSrc r%0d got %h exp %h", i, dSrc, eS); end
            checks++; if (dDst !== eD) begin errors++; $display("FAIL indep_dDst r%0d got %h exp %h", 15 - i, dDst, eD); end
        end
        // same address on both ports
        rSrc = 4'd9; rDst = 4'd9;
        expSrcQ.push_back(16'h0909); expDstQ.push_back(16'h0909);
        #1;
        eS = expSrcQ.pop_front(); eD = expDstQ.pop_front();
        checks++; if (dSrc !== eS || dDst !== eD) begin errors++; $display("FAIL same_addr got %h/%h exp %h/%h", dSrc, dDst, eS, eD); end
        // no bypass: pending write invisible until its edge
        @(negedge clk);
        write = 1'b1; rDst = 4'd5; rSrc = 4'd5; write_data = 16'hBEEF;
        expSrcQ.push_back(16'h0505);
        #1;
        eS = expSrcQ.pop_front();
        checks++; if (dSrc !== eS) begin errors++; $display("FAIL no_bypass_before got %h exp %h", dSrc, eS); end
        @(posedge clk);
        expSrcQ.push_back(16'hBEEF);
        #1;
        write = 1'b0;
        eS = expSrcQ.pop_front();
        checks++; if (dSrc !== eS) begin errors++; $display("FAIL no_bypass_after got %h exp %h", dSrc, eS); end
    endtask

    task automatic test_pc_isolation;
        logic [15:0] pcVals [4];
        pcVals[0] = 16'h0000; pcVals[1] = 16'hFFFF;
        pcVals[2] = 16'($urandom); pcVals[3] = 16'($urandom);
        // writes with pc toggling, same values as a plain run
        for (int i = 0; i < 16; i++) begin
            pc = pcVals[i % 4];
            doWrite(4'(i), 16'(16'hF000 ^ (i * 16'h0111)));
        end
        for (int i = 0; i < 16; i++) begin
            rSrc = 4'(i); rDst = 4'((i + 3) % 16);
            for (int p = 0; p < 4; p++) begin
                pc = pcVals[p];
                expSrcQ.push_back(16'(16'hF000 ^ (i * 16'h0111)));
                expDstQ.push_back(16'(16'hF000 ^ (((i + 3) % 16) * 16'h0111)));
                #0.5;
                eS = expSrcQ.pop_front(); eD = expDstQ.pop_front();
                checks++; if (dSrc !== eS) begin errors++; $display("FAIL pc_iso_dSrc r%0d pc %h got %h exp %h", i, pc, dSrc, eS); end
                checks++; if (dDst !== eD) begin errors++; $display("FAIL pc_iso_dDst r%0d pc %h got %h exp %h", (i + 3) % 16, pc, dDst, eD); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; write = 1'b0; rSrc = '0; rDst = '0;
        pc = '0; write_data = '0;
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;
        test_reset();
        test_write_all(16'h00FF, "wrall");
        test_write_all(16'h0000, "overwrite");
        test_write_disabled();
        test_independent();
        test_pc_isolation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
